// File: rtl/sramgen_sram_model_pipelined_if.sv
// Access bus for the SRAM22 behavioural model: requester drives the command,
// the memory returns registered read data, its valid flag and the sense-amp strobe.
interface sramgen_sram_model_pipelined_if #(
  parameter int DATA_WIDTH  = 24,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 1
);
  logic                   ce;
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   sae_int;

  modport master (
    output ce, we, wmask, addr, din,
    input  dout, dout_valid, sae_int
  );

  modport slave (
    input  ce, we, wmask, addr, din,
    output dout, dout_valid, sae_int
  );
endinterface

// File: rtl/sramgen_sram_model_pipelined.sv
// Parametrised single-port SRAM22 model with a READ_LATENCY-deep read pipeline.
// Optional macro SRAMGEN_WRITE_DOUT_X_EN: a write cycle drives dout to X.
module sramgen_sram_model_pipelined_lane #(
  parameter int LW         = 24,
  parameter int ADDR_WIDTH = 6,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LW-1:0]         din,
  output logic [LW-1:0]         rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [LW-1:0] FILL = (INIT_ZERO != 0) ? '0 : 'x;

  // Time-zero fill only; reset never touches the array.
  logic [LW-1:0] mem [DEPTH] = '{default: FILL};

  always_ff @(posedge clk)
    if (wr_en) mem[addr] <= din;

  assign rd_data = mem[addr];
endmodule

module sramgen_sram_model_pipelined #(
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 6,
  parameter int WMASK_WIDTH  = 1,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input logic                          clk,
  input logic                          reset,
  sramgen_sram_model_pipelined_if.slave bus
);
  localparam int LW     = DATA_WIDTH / WMASK_WIDTH;
  localparam int STAGES = READ_LATENCY - 1;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sramgen_sram_model_pipelined: READ_LATENCY %0d outside 1..4", READ_LATENCY);
  end
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_wmask
    $error("sramgen_sram_model_pipelined: WMASK_WIDTH %0d does not divide DATA_WIDTH %0d",
           WMASK_WIDTH, DATA_WIDTH);
  end

  logic                              rd_issue;
  logic                              wr_issue;
  logic [WMASK_WIDTH-1:0]            lane_wr;
  logic [WMASK_WIDTH-1:0][LW-1:0]    din_lanes;
  logic [WMASK_WIDTH-1:0][LW-1:0]    rd_lanes;
  logic [DATA_WIDTH-1:0]             rd_word;
  logic [STAGES:0]                   vld_pipe;
  logic                              emerge_v;
  logic [DATA_WIDTH-1:0]             emerge_d;

  // Reset outranks any access presented in the same cycle, writes included.
  assign rd_issue  = bus.ce & ~bus.we & ~reset;
  assign wr_issue  = bus.ce &  bus.we & ~reset;
  assign lane_wr   = bus.wmask & {WMASK_WIDTH{wr_issue}};
  assign din_lanes = bus.din;
  assign rd_word   = rd_lanes;

  for (genvar k = 0; k < WMASK_WIDTH; k++) begin : g_lane
    sramgen_sram_model_pipelined_lane #(
      .LW(LW), .ADDR_WIDTH(ADDR_WIDTH), .INIT_ZERO(INIT_ZERO)
    ) u_lane (
      .clk     (clk),
      .wr_en   (lane_wr[k]),
      .addr    (bus.addr),
      .din     (din_lanes[k]),
      .rd_data (rd_lanes[k])
    );
  end

  // vld_pipe[i] is set i edges after the issue edge; dout loads as vld_pipe[STAGES] sets.
  if (STAGES == 0) begin : g_direct
    assign emerge_v = rd_issue;
    assign emerge_d = rd_word;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] dat_pipe [STAGES];
    always_ff @(posedge clk) begin
      dat_pipe[0] <= rd_word;
      for (int i = 1; i < STAGES; i++) dat_pipe[i] <= dat_pipe[i-1];
    end
    assign emerge_v = vld_pipe[STAGES-1];
    assign emerge_d = dat_pipe[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe    <= '0;
      bus.dout    <= '0;
      bus.sae_int <= 1'b0;
    end else begin
      vld_pipe    <= (vld_pipe << 1) | (STAGES+1)'(rd_issue);
      bus.sae_int <= rd_issue;
      if (emerge_v) bus.dout <= emerge_d;
`ifdef SRAMGEN_WRITE_DOUT_X_EN
      else if (wr_issue) bus.dout <= 'x;
`endif
    end
  end

  assign bus.dout_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sramgen_sram_model_pipelined.sv
// Bench: latency-1 and latency-3 models driven in lockstep, read results scoreboarded.
module tb_sramgen_sram_model_pipelined;
  localparam int DW = 24;
  localparam int AW = 6;
  localparam int WM = 3;
  localparam int LW = DW / WM;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          ce    = 1'b0;
  logic          we    = 1'b0;
  logic [WM-1:0] wmask = '0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] din   = '0;

  always #5 clk = ~clk;

  sramgen_sram_model_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WM)) bus1 ();
  sramgen_sram_model_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WM)) bus3 ();

  assign bus1.ce = ce;  assign bus1.we = we;  assign bus1.wmask = wmask;
  assign bus1.addr = addr;  assign bus1.din = din;
  assign bus3.ce = ce;  assign bus3.we = we;  assign bus3.wmask = wmask;
  assign bus3.addr = addr;  assign bus3.din = din;

  sramgen_sram_model_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WM), .READ_LATENCY(1), .INIT_ZERO(1)
  ) u_l1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  sramgen_sram_model_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WM), .READ_LATENCY(3), .INIT_ZERO(1)
  ) u_l3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  typedef struct {
    int            dut;
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] mem_m [1<<AW];
  logic [DW-1:0] hold [2];
  bit            sae_exp  [int];
  bit            rst_edge [int];
  bit            wr_edge  [int];
  int            cyc    = 0;
  int            n_chk  = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Expected state for one model at the current negedge.
  task automatic mon(input int i, input string nm, input logic [DW-1:0] d,
                     input logic v, input logic s);
    logic [DW-1:0] ed;
    logic          ev;
    logic          es;
    int            idx [$];
    ed  = hold[i];
    ev  = 1'b0;
    es  = sae_exp.exists(cyc);
    idx = sb.find_first_index(x) with (x.dut == i);
    if (rst_edge.exists(cyc)) begin
      ed = '0;
      es = 1'b0;
    end else if (idx.size() > 0 && sb[idx[0]].due == cyc) begin
      ev = 1'b1;
      ed = sb[idx[0]].data;
      sb.delete(idx[0]);
    end
`ifdef SRAMGEN_WRITE_DOUT_X_EN
    else if (wr_edge.exists(cyc)) ed = 'x;
`endif
    hold[i] = ed;
    check({nm, ".dout"}, d, ed);
    check({nm, ".dout_valid"}, DW'(v), DW'(ev));
    check({nm, ".sae_int"}, DW'(s), DW'(es));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, "l1", bus1.dout, bus1.dout_valid, bus1.sae_int);
      mon(1, "l3", bus3.dout, bus3.dout_valid, bus3.sae_int);
    end
  end

  // Drives one cycle; the edge it takes effect at is cyc+1.
  task automatic step(input logic r, input logic c, input logic w, input logic [WM-1:0] m,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    @(posedge clk); #1;
    reset = r; ce = c; we = w; wmask = m; addr = a; din = d;
    if (r) begin
      rst_edge[cyc+1] = 1'b1;
      sb = sb.find(x) with (x.due <= cyc);
    end else if (c && w) begin
      for (int k = 0; k < WM; k++)
        if (m[k]) mem_m[a][k*LW +: LW] = d[k*LW +: LW];
      wr_edge[cyc+1] = 1'b1;
    end else if (c) begin
      e.dut = 0; e.due = cyc + 1; e.data = mem_m[a]; sb.push_back(e);
      e.dut = 1; e.due = cyc + 3; e.data = mem_m[a]; sb.push_back(e);
      sae_exp[cyc+1] = 1'b1;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WM-1:0] m);
    step(1'b0, 1'b1, 1'b1, m, a, d);
  endtask
  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b0, '0, a, '0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic rst();
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
    hold[0] = '0;
    hold[1] = '0;
    rst_edge[1] = 1'b1;
    rst_edge[2] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    mon_en = 1'b1;

    // basic write then read, full mask
    wr(6'd5, 24'hA5A5A5, 3'b111);
    rd(6'd5);
    idle(); @(negedge clk);
    check("t1.l1_dout", bus1.dout, 24'hA5A5A5);
    idle(); idle(); idle();

    // all-zero mask is a no-op write
    wr(6'd5, 24'h000000, 3'b000);
    rd(6'd5);
    idle(); idle(); idle(); idle();

    // partial lane write
    wr(6'd0, 24'hFFFFFF, 3'b111);
    wr(6'd0, 24'h123456, 3'b010);
    rd(6'd0);
    idle(); @(negedge clk);
    check("t2.l1_dout", bus1.dout, 24'hFF34FF);
    idle(); idle(); idle();

    // back-to-back reads stream out in order
    wr(6'd1, 24'h000011, 3'b111);
    wr(6'd2, 24'h000022, 3'b111);
    wr(6'd3, 24'h000033, 3'b111);
    rd(6'd1); rd(6'd2); rd(6'd3);
    idle(); idle(); idle(); idle();

    // reset while a latency-3 read is in flight
    rd(6'd3);
    rst();
    idle(); idle(); @(negedge clk);
    check("t4.l3_dout", bus3.dout, 24'h000000);
    check("t4.l3_valid", DW'(bus3.dout_valid), DW'(1'b0));
    rd(6'd1);
    idle(); idle(); idle(); idle();

    // ce low blocks the write
    step(1'b0, 1'b0, 1'b1, 3'b111, 6'd9, 24'hFFFFFF);
    rd(6'd9);
    idle(); @(negedge clk);
    check("t5.l1_dout", bus1.dout, 24'h000000);
    idle(); idle(); idle();

    // write right after a read: dout hold vs X
    wr(6'd7, 24'h777777, 3'b111);
    rd(6'd7);
    wr(6'd2, 24'h222222, 3'b111);
    idle(); @(negedge clk);
`ifdef SRAMGEN_WRITE_DOUT_X_EN
    check("t6.l1_dout", bus1.dout, 24'hxxxxxx);
`else
    check("t6.l1_dout", bus1.dout, 24'h777777);
`endif
    idle(); idle(); idle();
    rd(6'd2);
    idle(); idle(); idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
